// File: rtl/input_debouncer.sv
// Per-bit two-flop synchronizer and tick-sampled stability filter for raw pad inputs.
// Produces a debounced level and registered one-cycle rise/fall pulses per channel.
module input_debouncer #(
    parameter int WIDTH        = 6,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_out,
    output logic [WIDTH-1:0] fall_out,
    output logic             tick_out
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             tick_s;

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] clean_q;
    logic [WIDTH-1:0] clean_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        tick_s  = (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // A synchronized sample equal to the clean level wipes progress on any cycle,
    // so only uninterrupted disagreement across STABLE_TICKS ticks is accepted.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick_s && (cnt_q[i] == CNT_LAST)) begin
                cnt_d[i]   = '0;
                clean_d[i] = sync2_q[i];
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
            end else if (tick_s) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_out = clean_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;
    assign tick_out  = tick_s;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer with TICK_DIV=4, STABLE_TICKS=3.
module tb_input_debouncer;

    logic       clock;
    logic       reset;
    logic [5:0] raw_in;
    logic [5:0] clean_out;
    logic [5:0] rise_out;
    logic [5:0] fall_out;
    logic       tick_out;

    int checks;
    int errors;

    typedef struct {
        logic [5:0] raw;
        logic [5:0] clean;
        logic [5:0] rise;
        logic [5:0] fall;
    } vec_t;

    vec_t vecs [7];

    input_debouncer #(
        .WIDTH       (6),
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .raw_in   (raw_in),
        .clean_out(clean_out),
        .rise_out (rise_out),
        .fall_out (fall_out),
        .tick_out (tick_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " clean"}, {26'd0, clean_out}, 32'd0);
        chk({nm, " rise"}, {26'd0, rise_out}, 32'd0);
        chk({nm, " fall"}, {26'd0, fall_out}, 32'd0);
    endtask

    // Waits for clean_out to change, checking latency, value and a single-cycle pulse.
    task automatic measure(input string nm, input logic [5:0] ec, input logic [5:0] er,
                           input logic [5:0] ef);
        logic [5:0] prev;
        bit         done;
        prev = clean_out;
        done = 1'b0;
        for (int n = 1; n <= 20 && !done; n++) begin
            step();
            if (clean_out !== prev) begin
                done = 1'b1;
                checks++;
                if (n < 11 || n > 14) begin
                    errors++;
                    $display("FAIL %s latency actual %0d required 11..14", nm, n);
                end
                chk({nm, " clean"}, {26'd0, clean_out}, {26'd0, ec});
                chk({nm, " rise"}, {26'd0, rise_out}, {26'd0, er});
                chk({nm, " fall"}, {26'd0, fall_out}, {26'd0, ef});
            end else begin
                chk({nm, " early pulse"}, {26'd0, rise_out | fall_out}, 32'd0);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual %0h required %0h", nm, clean_out, ec);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            chk({nm, " after rise"}, {26'd0, rise_out}, 32'd0);
            chk({nm, " after fall"}, {26'd0, fall_out}, 32'd0);
            chk({nm, " held"}, {26'd0, clean_out}, {26'd0, ec});
        end
    endtask

    initial begin
        int ticks;
        bit tick_was;

        checks = 0;
        errors = 0;
        vecs[0] = '{raw: 6'h01, clean: 6'h01, rise: 6'h01, fall: 6'h00};
        vecs[1] = '{raw: 6'h00, clean: 6'h00, rise: 6'h00, fall: 6'h01};
        vecs[2] = '{raw: 6'h3F, clean: 6'h3F, rise: 6'h3F, fall: 6'h00};
        vecs[3] = '{raw: 6'h00, clean: 6'h00, rise: 6'h00, fall: 6'h3F};
        vecs[4] = '{raw: 6'h2A, clean: 6'h2A, rise: 6'h2A, fall: 6'h00};
        vecs[5] = '{raw: 6'h15, clean: 6'h15, rise: 6'h15, fall: 6'h2A};
        vecs[6] = '{raw: 6'h00, clean: 6'h00, rise: 6'h00, fall: 6'h15};

        reset  = 1'b1;
        raw_in = 6'h00;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all_zero("in reset");
            chk("in reset tick", {31'd0, tick_out}, 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Idle: outputs stay 0, tick every 4th cycle starting at the 4th.
        for (int n = 1; n <= 100; n++) begin
            step();
            chk_all_zero("idle");
            chk("idle tick", {31'd0, tick_out}, (n % 4 == 3) ? 32'd1 : 32'd0);
        end

        for (int v = 0; v < 7; v++) begin
            raw_in = vecs[v].raw;
            measure($sformatf("vec%0d", v), vecs[v].clean, vecs[v].rise, vecs[v].fall);
        end

        // Bounce on bit 1: 5-cycle half periods never span three ticks.
        for (int w = 0; w < 40; w++) begin
            raw_in = (w % 2 == 0) ? 6'h02 : 6'h00;
            for (int k = 0; k < 5; k++) begin
                step();
                chk_all_zero("bounce");
            end
        end
        raw_in = 6'h02;
        measure("bounce hold", 6'h02, 6'h02, 6'h00);
        raw_in = 6'h00;
        measure("bounce release", 6'h00, 6'h00, 6'h02);

        // Reset between the 2nd and 3rd tick of a pending acceptance on bit 2.
        raw_in = 6'h04;
        ticks  = 0;
        for (int n = 0; n < 20 && ticks < 2; n++) begin
            tick_was = tick_out;
            step();
            if (tick_was) ticks++;
        end
        chk("mid ticks seen", ticks, 32'd2);
        chk("mid clean before reset", {26'd0, clean_out}, 32'd0);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("async reset");
        chk("async reset tick", {31'd0, tick_out}, 32'd0);
        step();
        step();
        @(negedge clock);
        reset = 1'b0;
        measure("after mid reset", 6'h04, 6'h04, 6'h00);
        raw_in = 6'h00;
        measure("after mid reset release", 6'h00, 6'h00, 6'h04);

        // Input already high across reset release is debounced as a rise.
        @(negedge clock);
        raw_in = 6'h08;
        reset  = 1'b1;
        step();
        step();
        chk_all_zero("reset with input high");
        @(negedge clock);
        reset = 1'b0;
        measure("high at release", 6'h08, 6'h08, 6'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
